// File: rtl/biriscv_mul_wb_tracker_if.sv
// Handshake bundle between the multiply issue stage, the multiplier writeback
// and the register-file writeback arbiter for the multiply result tracker.
interface biriscv_mul_wb_tracker_if;
  logic        issue_valid_i;
  logic        issue_mul_i;
  logic [4:0]  issue_rd_idx_i;
  logic [31:0] issue_pc_i;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] mul_value_i;
  logic        wb_ready_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_value_o;
  logic [31:0] pending_rd_mask_o;
  logic        stall_o;

  // Pipeline / arbiter side: drives issue, hold, flush, value and ready.
  modport master (
    output issue_valid_i, issue_mul_i, issue_rd_idx_i, issue_pc_i,
    output hold_i, flush_i, mul_value_i, wb_ready_i,
    input  wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o,
    input  pending_rd_mask_o, stall_o
  );

  // Tracker side.
  modport slave (
    input  issue_valid_i, issue_mul_i, issue_rd_idx_i, issue_pc_i,
    input  hold_i, flush_i, mul_value_i, wb_ready_i,
    output wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o,
    output pending_rd_mask_o, stall_o
  );
endinterface

// File: rtl/biriscv_mul_wb_tracker.sv
// Tags each issued multiply through the multiplier stages, pairs it with the
// final-stage result, and buffers completed results for register writeback.
module biriscv_mul_wb_tracker #(
  parameter int MULT_STAGES   = 2,
  parameter int WB_FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  biriscv_mul_wb_tracker_if.slave     bus
);

  localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
  localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);
  localparam int LAST  = MULT_STAGES - 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
  } tag_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] value;
  } entry_t;

  logic [MULT_STAGES-1:0] tag_valid_q;
  tag_t                   tag_q [MULT_STAGES];
  entry_t                 fifo_mem_q [WB_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       fifo_count_q;

  logic accept;
  logic push;
  logic pop;

  assign accept = bus.issue_valid_i & bus.issue_mul_i & ~bus.hold_i & ~bus.flush_i;
  // The tag leaves the final stage on the capture edge, so a hold never re-captures it.
  assign push   = tag_valid_q[LAST] & ~bus.hold_i & ~bus.flush_i;
  assign pop    = (fifo_count_q != '0) & bus.wb_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid_q <= '0;
    end else if (bus.flush_i) begin
      tag_valid_q <= '0;
    end else if (!bus.hold_i) begin
      tag_valid_q <= {tag_valid_q[MULT_STAGES-2:0], accept};
    end
  end

  // NOTE: tag payloads and FIFO storage carry no reset; they are only observed behind a valid bit or the count.
  always_ff @(posedge clk_i) begin
    if (!bus.hold_i) begin
      tag_q[0] <= '{rd: bus.issue_rd_idx_i, pc: bus.issue_pc_i};
      for (int i = 1; i < MULT_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{rd: tag_q[LAST].rd, pc: tag_q[LAST].pc, value: bus.mul_value_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Head fields read storage directly and are zeroed while empty so reset shows all-zero outputs.
  entry_t head;
  assign head               = fifo_mem_q[rd_ptr_q];
  assign bus.wb_valid_o     = (fifo_count_q != '0);
  assign bus.wb_rd_idx_o    = bus.wb_valid_o ? head.rd    : '0;
  assign bus.wb_pc_o        = bus.wb_valid_o ? head.pc    : '0;
  assign bus.wb_value_o     = bus.wb_valid_o ? head.value : '0;

  logic [CNT_W:0]   occupancy;
  logic [PTR_W-1:0] offset;
  logic [31:0]      mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    occupancy = {1'b0, fifo_count_q};
    for (int i = 0; i < MULT_STAGES; i++) begin
      occupancy = occupancy + (CNT_W+1)'(tag_valid_q[i]);
    end
  end

  // Credits: in-flight tags already own a FIFO slot, so stall before they could overrun it.
  assign bus.stall_o = (occupancy >= (CNT_W+1)'(WB_FIFO_DEPTH));

  always_comb begin
    mask   = '0;
    offset = '0;
    for (int i = 0; i < MULT_STAGES; i++) begin
      if (tag_valid_q[i]) mask[tag_q[i].rd] = 1'b1;
    end
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(offset) < fifo_count_q) mask[fifo_mem_q[i].rd] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign bus.pending_rd_mask_o = mask;

endmodule

// File: tb/tb_biriscv_mul_wb_tracker.sv
// Self-checking bench for biriscv_mul_wb_tracker: per-cycle vector table plus
// hand-written corner sequences, with a writeback scoreboard.
module tb_biriscv_mul_wb_tracker;

  localparam int S = 2;
  localparam int D = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  biriscv_mul_wb_tracker_if bus();

  biriscv_mul_wb_tracker #(.MULT_STAGES(S), .WB_FIFO_DEPTH(D)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic        ready;
    logic        exp_stall;
    logic        exp_wbv;
    logic [31:0] exp_mask;
  } vec_t;

  exp_t        sb_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] mult_sh [S];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, record expected writeback, advance, then update the multiplier model.
  task automatic step(input logic iv, input logic [4:0] rd, input logic [31:0] pc,
                      input logic hold, input logic flush, input logic ready,
                      input bit expect_wb = 1'b1);
    bus.issue_valid_i  = iv;
    bus.issue_mul_i    = iv;
    bus.issue_rd_idx_i = rd;
    bus.issue_pc_i     = pc;
    bus.hold_i         = hold;
    bus.flush_i        = flush;
    bus.wb_ready_i     = ready;
    if (iv && !hold && !flush && !rst_i && expect_wb)
      sb_q.push_back(exp_t'{rd, pc, pc * 32'd12});
    @(posedge clk_i);
    #1;
    if (!hold) begin
      for (int i = S - 1; i > 0; i--) mult_sh[i] = mult_sh[i-1];
      mult_sh[0] = pc * 32'd12;
    end
    bus.mul_value_i = mult_sh[S-1];
  endtask

  task automatic idle(input logic ready);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, ready);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) idle(1'b1);
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: a writeback is taken at the edge following this sample.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && bus.wb_valid_o === 1'b1 && bus.wb_ready_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL wb_unexpected: got rd %0d pc 0x%08h, expected no writeback",
                 bus.wb_rd_idx_o, bus.wb_pc_o);
      end else begin
        e = sb_q.pop_front();
        check("wb_rd",    32'(bus.wb_rd_idx_o), 32'(e.rd));
        check("wb_pc",    bus.wb_pc_o,          e.pc);
        check("wb_value", bus.wb_value_o,       e.value);
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(dut.push && !dut.pop && dut.fifo_count_q == D))
      else begin
        tests_failed++;
        $display("FAIL fifo_overflow: push with count %0d, expected count below %0d",
                 dut.fifo_count_q, D);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs [11];
  logic go;
  int   nxt;

  initial begin
    vecs[0]  = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0002};
    vecs[1]  = '{1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0006};
    vecs[2]  = '{1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0000_000E};
    vecs[3]  = '{1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 32'h0000_001E};
    vecs[4]  = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_001E};
    vecs[5]  = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_001E};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_001E};
    vecs[7]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_001C};
    vecs[8]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0018};
    vecs[9]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    vecs[10] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

    for (int i = 0; i < S; i++) mult_sh[i] = '0;
    bus.mul_value_i = '0;

    // Reset state.
    rst_i = 1'b1;
    idle(1'b0);
    idle(1'b0);
    check("rst_wbv",   32'(bus.wb_valid_o), 32'd0);
    check("rst_mask",  bus.pending_rd_mask_o, 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_pc",    bus.wb_pc_o, 32'd0);
    rst_i = 1'b0;

    // Single issue: latency and mask lifetime.
    step(1'b1, 5'd5, 32'h100, 1'b0, 1'b0, 1'b1);
    check("t1_wbv_e0",  32'(bus.wb_valid_o), 32'd0);
    check("t1_mask_e0", bus.pending_rd_mask_o, 32'h20);
    idle(1'b1);
    check("t1_wbv_e1",  32'(bus.wb_valid_o), 32'd0);
    check("t1_mask_e1", bus.pending_rd_mask_o, 32'h20);
    idle(1'b1);
    check("t1_wbv_e2",   32'(bus.wb_valid_o), 32'd1);
    check("t1_rd_e2",    32'(bus.wb_rd_idx_o), 32'd5);
    check("t1_value_e2", bus.wb_value_o, 32'h0000_0C00);
    check("t1_mask_e2",  bus.pending_rd_mask_o, 32'h20);
    idle(1'b1);
    check("t1_wbv_e3",  32'(bus.wb_valid_o), 32'd0);
    check("t1_mask_e3", bus.pending_rd_mask_o, 32'd0);

    // Back-to-back fill to the credit limit, then ordered drain.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].iv, vecs[i].rd, 32'h200 + 32'(vecs[i].rd) * 4, 1'b0, 1'b0, vecs[i].ready);
      check($sformatf("t2_stall_%0d", i), 32'(bus.stall_o),    32'(vecs[i].exp_stall));
      check($sformatf("t2_wbv_%0d", i),   32'(bus.wb_valid_o), 32'(vecs[i].exp_wbv));
      check($sformatf("t2_mask_%0d", i),  bus.pending_rd_mask_o, vecs[i].exp_mask);
    end

    // Hold three cycles with the tag in the final stage.
    step(1'b1, 5'd9, 32'h300, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      check($sformatf("t3_wbv_hold%0d", i), 32'(bus.wb_valid_o), 32'd0);
    end
    idle(1'b0);
    check("t3_wbv_cap",   32'(bus.wb_valid_o), 32'd1);
    check("t3_value_cap", bus.wb_value_o, 32'h0000_2400);
    idle(1'b0);
    check("t3_value_stable", bus.wb_value_o, 32'h0000_2400);
    check("t3_rd_stable",    32'(bus.wb_rd_idx_o), 32'd9);
    idle(1'b1);
    check("t3_single_capture", 32'(bus.wb_valid_o), 32'd0);

    // Flush with rd=7 buffered and rd=8 in stage 1.
    step(1'b1, 5'd7, 32'h400, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 5'd8, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_mask_pre", bus.pending_rd_mask_o, 32'h0000_0180);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t4_mask_flush", bus.pending_rd_mask_o, 32'h0000_0080);
    idle(1'b0);
    idle(1'b0);
    check("t4_mask_after", bus.pending_rd_mask_o, 32'h0000_0080);
    check("t4_head_rd",    32'(bus.wb_rd_idx_o), 32'd7);
    drain("t4_drain");
    idle(1'b1);
    check("t4_wbv_empty", 32'(bus.wb_valid_o), 32'd0);

    // Fill the FIFO, then stream with simultaneous push/pop across pointer wrap.
    nxt = 16;
    for (int c = 0; c < 8; c++) begin
      go = !bus.stall_o;
      step(go, nxt[4:0], 32'h500 + 32'(nxt) * 4, 1'b0, 1'b0, 1'b0);
      if (go) nxt++;
    end
    check("t5_full_stall", 32'(bus.stall_o), 32'd1);
    check("t5_full_count", 32'(dut.fifo_count_q), 32'd4);
    for (int c = 0; c < 14; c++) begin
      go = !bus.stall_o;
      step(go, nxt[4:0], 32'h500 + 32'(nxt) * 4, 1'b0, 1'b0, 1'b1);
      if (go) nxt++;
      if (c >= 3) begin
        check($sformatf("t5_steady_count_%0d", c), 32'(dut.fifo_count_q), 32'd1);
        check($sformatf("t5_steady_wbv_%0d", c),   32'(bus.wb_valid_o), 32'd1);
      end
    end
    drain("t5_drain");

    // Reset with two in flight and two buffered.
    step(1'b1, 5'd10, 32'h600, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd11, 32'h604, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd12, 32'h608, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd13, 32'h60C, 1'b0, 1'b0, 1'b0);
    check("t6_stall_pre", 32'(bus.stall_o), 32'd1);
    rst_i = 1'b1;
    sb_q.delete();
    idle(1'b0);
    check("t6_wbv",   32'(bus.wb_valid_o), 32'd0);
    check("t6_mask",  bus.pending_rd_mask_o, 32'd0);
    check("t6_stall", 32'(bus.stall_o), 32'd0);
    check("t6_rd",    32'(bus.wb_rd_idx_o), 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check($sformatf("t6_no_stale_%0d", i), 32'(bus.wb_valid_o), 32'd0);
    end

    // rd=0 is written back but never marks the scoreboard mask.
    step(1'b1, 5'd0, 32'h700, 1'b0, 1'b0, 1'b1);
    check("t7_mask_e0", bus.pending_rd_mask_o, 32'd0);
    idle(1'b1);
    check("t7_mask_e1", bus.pending_rd_mask_o, 32'd0);
    idle(1'b1);
    check("t7_wbv",     32'(bus.wb_valid_o), 32'd1);
    check("t7_rd",      32'(bus.wb_rd_idx_o), 32'd0);
    check("t7_mask_e2", bus.pending_rd_mask_o, 32'd0);
    drain("t7_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/biriscv_mul_wb_tracker.md
Name: biriscv_mul_wb_tracker

Overview:
- Downstream companion of the pipelined multiplier. Tracks each issued multiply (rd index, pc) through the multiplier's E1..E2/E3 stages.
- Pairs each tag with the multiplier's result at the final stage and buffers completed results in a small FIFO. Presents them to the register-file writeback arbiter with a valid/ready handshake.
- Exports a pending-rd scoreboard and an issue stall so the multiplier pipeline never overruns the buffer.

Parameters:
MULT_STAGES, 2, multiplier latency in stages (2 or 3); must match the multiplier instance.
WB_FIFO_DEPTH, 4, completed-result buffer entries; power of two, >= MULT_STAGES.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
issue_valid_i  in  1  instruction presented to the multiplier this cycle
issue_mul_i  in  1  instruction is MUL/MULH/MULHSU/MULHU
issue_rd_idx_i  in  5  destination register
issue_pc_i  in  32  instruction pc
hold_i  in  1  pipeline hold; same signal that drives the multiplier's hold
flush_i  in  1  kill all in-flight (not yet buffered) multiplies
mul_value_i  in  32  multiplier writeback value (final-stage register)
wb_ready_i  in  1  writeback arbiter accepts the current head entry
wb_valid_o  out  1  head entry valid
wb_rd_idx_o  out  5  head rd
wb_pc_o  out  32  head pc
wb_value_o  out  32  head result
pending_rd_mask_o  out  32  bit r set if any in-flight or buffered op targets r (r != 0)
stall_o  out  1  upstream must not issue a multiply this cycle

Behaviour:
- Reset: all tag-stage valids, the FIFO count and pointers, and all outputs are 0. Reset is synchronous and active-high, and has priority over every other event, including mid-operation (in-flight and buffered entries are discarded).
- Issue accept: issue_valid_i & issue_mul_i & ~hold_i & ~flush_i. On accept, {valid, rd, pc} loads tag stage 1. Otherwise stage 1 loads valid=0 when ~hold_i.
- Tag pipeline:
  - Stages 1..MULT_STAGES shift by one on each edge with ~hold_i.
  - With hold_i, all stages keep their contents.
  - The final stage is time-aligned with mul_value_i.
- Capture: when final-stage valid & ~hold_i & ~flush_i, push {rd, pc, mul_value_i} into the FIFO at that edge. Because the tag leaves the final stage on the same edge, there is no duplicate capture while held.
- Flush: at the edge with flush_i, all tag-stage valids clear and there is no capture that cycle. FIFO contents are preserved. flush_i overrides hold_i for the tag valids.
- FIFO:
  - Pop on wb_valid_o & wb_ready_i.
  - Push and pop in the same cycle: count unchanged, pointers advance, wrap modulo WB_FIFO_DEPTH.
  - wb_valid_o = count != 0. The wb_* head fields are driven from FIFO storage, with no push-to-output bypass.
  - Head fields are stable while wb_valid_o & ~wb_ready_i.
  - wb_ready_i is ignored while the FIFO is empty.
- Latency: an issue accepted at edge 0 with no hold gives wb_valid_o in the cycle after edge MULT_STAGES. Each hold cycle adds one cycle.
- Credits / stall_o:
  - stall_o is combinational: (count + number of valid tag stages) >= WB_FIFO_DEPTH.
  - Upstream must fold stall_o into hold.
  - An issue presented while stall_o is high is a protocol violation. The tracker does not track it.
  - Overflow is therefore impossible. Push while full is a protocol error and must be covered by a bench assertion.
- Ordering: strictly in issue order, with no reordering.
- pending_rd_mask_o:
  - Combinational OR of one-hot(rd) over all valid tag stages and all FIFO entries.
  - Bit 0 is forced to 0.
  - Multiplies with rd=0 are tracked and written back but never set mask bits.
  - An entry's bit clears in the cycle after its pop edge, unless another pending entry uses the same rd.

Test Plan:
1. Reset, MULT_STAGES=2; issue rd=5, pc=0x100, with mul_value_i=0x0000_0C00 at the final stage, wb_ready_i=1.
   - Required: wb_valid_o high exactly 2 cycles after issue with rd=5, pc=0x100, value=0x0C00.
   - Required: mask bit 5 set from the cycle after issue until the cycle after pop.
2. Back-to-back issues rd=1,2,3,4 with wb_ready_i=0.
   - Required: stall_o rises when the in-flight plus buffered count reaches 4; FIFO holds 4 entries in order; no overflow.
   - Then raise wb_ready_i: 4 pops in rd order 1,2,3,4, one per cycle.
3. Hold for 3 cycles while a tag is in stage 2.
   - Required: exactly one capture; latency extends by 3; value equals the held mul_value_i.
4. Issue rd=7 then rd=8; assert flush_i while rd=8 is in stage 1 and rd=7 is buffered.
   - Required: rd=7 is still written back; rd=8 never appears; mask bit 8 clears after the flush edge.
5. FIFO full plus simultaneous push/pop with wb_ready_i=1, over 8 or more ops.
   - Required: pointer wrap-around and correct order, with count constant at the steady-state value.
6. Assert rst_i with 2 in flight and 2 buffered.
   - Required: the next cycle shows wb_valid_o=0, mask=0, stall_o=0, and no stale writeback afterwards.
7. Issue with rd=0.
   - Required: it is written back with wb_rd_idx_o=0, and pending_rd_mask_o stays 0.
